// File: rtl/port_a_input.sv
// Debounced 8-bit input port with per-bit change flags (PORTA / IOCF) exposed
// in the CPU file-register space.
module port_a_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [6:0]  PORT_ADDR       = 7'h05,
  parameter logic [6:0]  IOCF_ADDR       = 7'h09
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pin_in,
  input  logic [6:0] addr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       rd_hit,
  output logic [7:0] rd_data,
  output logic [7:0] port_a_q,
  output logic [7:0] iocf_q,
  output logic       ioc_pending
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    chg;
  logic [7:0]    iocf_next;
  logic          iocf_wr;
  logic [CW-1:0] cnt [8];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

  // A bit is accepted on the sample that completes DEBOUNCE_CYCLES differing samples.
  always_comb begin
    chg = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      chg[i] = (sync2[i] != port_a_q[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_a_q <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (sync2[i] == port_a_q[i]) begin
          cnt[i] <= '0;
        end else if (chg[i]) begin
          port_a_q[i] <= sync2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A change flag set wins over a simultaneous firmware write of 0.
  always_comb begin
    iocf_wr   = wr_en && (addr == IOCF_ADDR);
    iocf_next = chg | (iocf_wr ? wr_data : iocf_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iocf_q <= '0;
    end else begin
      iocf_q <= iocf_next;
    end
  end

  always_comb begin
    rd_hit  = (addr == PORT_ADDR) || (addr == IOCF_ADDR);
    rd_data = '0;
    if (addr == PORT_ADDR) begin
      rd_data = port_a_q;
    end else if (addr == IOCF_ADDR) begin
      rd_data = iocf_q;
    end
  end

  assign ioc_pending = |iocf_q;

endmodule

// File: tb/tb_port_a_input.sv
// Directed testbench for port_a_input: debounce latency, glitch rejection,
// IOCF write/set priority, address decode and reset behaviour.
module tb_port_a_input;

  logic       clk;
  logic       reset;
  logic [7:0] pin_in;
  logic [6:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_hit;
  logic [7:0] rd_data;
  logic [7:0] port_a_q;
  logic [7:0] iocf_q;
  logic       ioc_pending;

  logic       d1_rd_hit;
  logic [7:0] d1_rd_data;
  logic [7:0] d1_port_a_q;
  logic [7:0] d1_iocf_q;
  logic       d1_ioc_pending;

  int checks;
  int errors;

  port_a_input #(.DEBOUNCE_CYCLES(4), .PORT_ADDR(7'h05), .IOCF_ADDR(7'h09)) dut (
    .clk(clk), .reset(reset), .pin_in(pin_in), .addr(addr), .wr_en(wr_en),
    .wr_data(wr_data), .rd_hit(rd_hit), .rd_data(rd_data), .port_a_q(port_a_q),
    .iocf_q(iocf_q), .ioc_pending(ioc_pending)
  );

  port_a_input #(.DEBOUNCE_CYCLES(1), .PORT_ADDR(7'h05), .IOCF_ADDR(7'h09)) dut_d1 (
    .clk(clk), .reset(reset), .pin_in(pin_in), .addr(addr), .wr_en(wr_en),
    .wr_data(wr_data), .rd_hit(d1_rd_hit), .rd_data(d1_rd_data), .port_a_q(d1_port_a_q),
    .iocf_q(d1_iocf_q), .ioc_pending(d1_ioc_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pin_in = 8'hFF;
    repeat (3) step();
    checks++; if (port_a_q !== 8'h00) begin errors++; $display("FAIL reset_port got %h want 00", port_a_q); end
    checks++; if (iocf_q !== 8'h00) begin errors++; $display("FAIL reset_iocf got %h want 00", iocf_q); end
    checks++; if (ioc_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", ioc_pending); end
    reset = 1'b0;
    step();               // edge R
    repeat (4) step();    // R+1 .. R+4
    checks++; if (port_a_q !== 8'h00) begin errors++; $display("FAIL release_early got %h want 00", port_a_q); end
    step();               // R+5
    checks++; if (port_a_q !== 8'hFF) begin errors++; $display("FAIL release_port got %h want ff", port_a_q); end
    checks++; if (iocf_q !== 8'hFF) begin errors++; $display("FAIL release_iocf got %h want ff", iocf_q); end
    checks++; if (ioc_pending !== 1'b1) begin errors++; $display("FAIL release_pending got %b want 1", ioc_pending); end
  endtask

  task automatic test_glitch();
    reset = 1'b1; pin_in = 8'h00;
    repeat (2) step();
    reset = 1'b0;
    step();
    checks++; if (port_a_q !== 8'h00 || iocf_q !== 8'h00) begin errors++; $display("FAIL glitch_base got %h/%h want 00/00", port_a_q, iocf_q); end
    pin_in = 8'h01;
    repeat (3) step();
    pin_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (port_a_q !== 8'h00) begin errors++; $display("FAIL glitch_port cyc %0d got %h want 00", i, port_a_q); end
    end
    checks++; if (iocf_q !== 8'h00) begin errors++; $display("FAIL glitch_iocf got %h want 00", iocf_q); end
  endtask

  task automatic test_accept_latency();
    pin_in = 8'h08;
    step();   // E0
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (port_a_q !== 8'h00 || iocf_q !== 8'h00) begin errors++; $display("FAIL latency_early E0+%0d got %h/%h want 00/00", i, port_a_q, iocf_q); end
    end
    step();   // E0+5
    checks++; if (port_a_q !== 8'h08) begin errors++; $display("FAIL latency_port got %h want 08", port_a_q); end
    checks++; if (iocf_q !== 8'h08) begin errors++; $display("FAIL latency_iocf got %h want 08", iocf_q); end
    addr = 7'h05; #1;
    checks++; if (rd_hit !== 1'b1 || rd_data !== 8'h08) begin errors++; $display("FAIL read_porta got %b/%h want 1/08", rd_hit, rd_data); end
    addr = 7'h09; #1;
    checks++; if (rd_hit !== 1'b1 || rd_data !== 8'h08) begin errors++; $display("FAIL read_iocf got %b/%h want 1/08", rd_hit, rd_data); end
  endtask

  task automatic test_iocf_write();
    addr = 7'h09; wr_data = 8'h00; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if (iocf_q !== 8'h00 || ioc_pending !== 1'b0) begin errors++; $display("FAIL iocf_clear got %h/%b want 00/0", iocf_q, ioc_pending); end
    pin_in = 8'h28;
    step();             // E0
    repeat (4) step();  // E0+4
    checks++; if (iocf_q !== 8'h00) begin errors++; $display("FAIL iocf_pre_set got %h want 00", iocf_q); end
    wr_en = 1'b1; wr_data = 8'h00;
    step();             // E0+5: accept and write 0 together
    wr_en = 1'b0;
    checks++; if (iocf_q !== 8'h20) begin errors++; $display("FAIL iocf_set_wins got %h want 20", iocf_q); end
    checks++; if (port_a_q !== 8'h28) begin errors++; $display("FAIL iocf_port got %h want 28", port_a_q); end
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    checks++; if (iocf_q !== 8'hA5 || rd_data !== 8'hA5) begin errors++; $display("FAIL iocf_write got %h/%h want a5/a5", iocf_q, rd_data); end
    wr_en = 1'b1; wr_data = 8'h20;
    step();
    wr_en = 1'b0;
    checks++; if (iocf_q !== 8'h20) begin errors++; $display("FAIL iocf_restore got %h want 20", iocf_q); end
  endtask

  task automatic test_decode();
    addr = 7'h05; wr_data = 8'h55; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if (port_a_q !== 8'h28 || iocf_q !== 8'h20) begin errors++; $display("FAIL porta_write got %h/%h want 28/20", port_a_q, iocf_q); end
    addr = 7'h20; wr_data = 8'hFF; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if (iocf_q !== 8'h20) begin errors++; $display("FAIL other_write got %h want 20", iocf_q); end
    checks++; if (rd_hit !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL other_read got %b/%h want 0/00", rd_hit, rd_data); end
    addr = 7'h09; wr_data = 8'h00; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if (iocf_q !== 8'h00) begin errors++; $display("FAIL decode_clear got %h want 00", iocf_q); end
  endtask

  task automatic test_falling();
    pin_in = 8'h20;
    step();             // E0
    repeat (4) step();
    checks++; if (port_a_q !== 8'h28) begin errors++; $display("FAIL fall_early got %h want 28", port_a_q); end
    step();             // E0+5
    checks++; if (port_a_q !== 8'h20 || iocf_q !== 8'h08) begin errors++; $display("FAIL fall_accept got %h/%h want 20/08", port_a_q, iocf_q); end
    addr = 7'h09; wr_data = 8'h00; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 12; i++) begin
      pin_in = pin_in ^ 8'h02;
      step();
      checks++; if (port_a_q !== 8'h20) begin errors++; $display("FAIL toggle_port cyc %0d got %h want 20", i, port_a_q); end
    end
    repeat (6) step();
    checks++; if (port_a_q !== 8'h20 || iocf_q !== 8'h00) begin errors++; $display("FAIL toggle_end got %h/%h want 20/00", port_a_q, iocf_q); end
  endtask

  task automatic test_reset_mid();
    pin_in = 8'hA0;
    step();             // E0
    repeat (2) step();  // E0+2
    reset = 1'b1;
    step();             // E0+3
    reset = 1'b0;
    checks++; if (port_a_q !== 8'h00 || iocf_q !== 8'h00) begin errors++; $display("FAIL midreset_clear got %h/%h want 00/00", port_a_q, iocf_q); end
    for (int i = 4; i <= 7; i++) begin
      step();
      checks++; if (port_a_q !== 8'h00 || iocf_q !== 8'h00) begin errors++; $display("FAIL midreset_hold E0+%0d got %h/%h want 00/00", i, port_a_q, iocf_q); end
    end
    repeat (2) step();  // E0+9: full new count after reset release
    checks++; if (port_a_q !== 8'hA0 || iocf_q !== 8'hA0) begin errors++; $display("FAIL midreset_accept got %h/%h want a0/a0", port_a_q, iocf_q); end
  endtask

  task automatic test_d1();
    reset = 1'b1; pin_in = 8'h00;
    repeat (2) step();
    reset = 1'b0;
    step();
    pin_in = 8'h81;
    step();             // E0
    step();             // E0+1
    checks++; if (d1_port_a_q !== 8'h00) begin errors++; $display("FAIL d1_early got %h want 00", d1_port_a_q); end
    step();             // E0+2
    checks++; if (d1_port_a_q !== 8'h81 || d1_iocf_q !== 8'h81) begin errors++; $display("FAIL d1_accept got %h/%h want 81/81", d1_port_a_q, d1_iocf_q); end
    checks++; if (port_a_q !== 8'h00) begin errors++; $display("FAIL d4_vs_d1 got %h want 00", port_a_q); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; pin_in = 8'h00; addr = 7'h00; wr_en = 1'b0; wr_data = 8'h00;
    test_reset();
    test_glitch();
    test_accept_latency();
    test_iocf_write();
    test_decode();
    test_falling();
    test_toggle();
    test_reset_mid();
    test_d1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
